layer_tile_planner: RTL and testbench

LAYER_TILE_PLANNER -- requirements
Module: layer_tile_planner

---
 rtl/layer_tile_planner_if.sv | 62 ++++++
 rtl/layer_tile_planner.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_layer_tile_planner.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_tile_planner_if.sv
// layer_tile_planner_if: descriptor/result bundle for the layer tile planner.
//
// Signals (named from the planner's point of view):
//   flush_i                 synchronous abort
//   in_valid_i / in_ready_o descriptor handshake
//   layer_type_i            0=PW, 1=DW, 2=STD, 3=LIN
//   in_R_i, in_C_i          input spatial size (DIM_W)
//   in_D_i, out_K_i         input / output channel counts (CH_W)
//   stride_i, pad_*_i       stride and per-side padding (2 bits each)
//   out_valid_o/out_ready_i result handshake
//   out_R_o, out_C_o        output spatial size (DIM_W)
//   padded_R_o, padded_C_o  padded input size (DIM_W)
//   tile_D_o, tile_K_o      channel tile sizes (7 bits)
//   tile_n_o                spatial tile count, multiple of 4 (DIV_W)
//   err_o                   descriptor could not be planned
//
// Modports: master drives descriptors (bench / upstream), slave is the planner.
`timescale 1ns/1ps

interface layer_tile_planner_if #(
  parameter int unsigned DIM_W = 7,
  parameter int unsigned CH_W  = 11,
  parameter int unsigned DIV_W = 32
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       layer_type_i;
  logic [DIM_W-1:0] in_R_i;
  logic [DIM_W-1:0] in_C_i;
  logic [CH_W-1:0]  in_D_i;
  logic [CH_W-1:0]  out_K_i;
  logic [1:0]       stride_i;
  logic [1:0]       pad_T_i;
  logic [1:0]       pad_B_i;
  logic [1:0]       pad_L_i;
  logic [1:0]       pad_R_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DIM_W-1:0] out_R_o;
  logic [DIM_W-1:0] out_C_o;
  logic [DIM_W-1:0] padded_R_o;
  logic [DIM_W-1:0] padded_C_o;
  logic [6:0]       tile_D_o;
  logic [6:0]       tile_K_o;
  logic [DIV_W-1:0] tile_n_o;
  logic             err_o;

  modport master (
    output flush_i, in_valid_i, layer_type_i, in_R_i, in_C_i, in_D_i, out_K_i,
           stride_i, pad_T_i, pad_B_i, pad_L_i, pad_R_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_R_o, out_C_o, padded_R_o, padded_C_o,
           tile_D_o, tile_K_o, tile_n_o, err_o
  );

  modport slave (
    input  flush_i, in_valid_i, layer_type_i, in_R_i, in_C_i, in_D_i, out_K_i,
           stride_i, pad_T_i, pad_B_i, pad_L_i, pad_R_i, out_ready_i,
    output in_ready_o, out_valid_o, out_R_o, out_C_o, padded_R_o, padded_C_o,
           tile_D_o, tile_K_o, tile_n_o, err_o
  );
endinterface

// File: rtl/layer_tile_planner.sv
// layer_tile_planner: plans output size and tile sizes for one CNN layer descriptor.
//
// Accepts a descriptor in IDLE, derives padded size, kernel and channel tiles in
// LOAD, then runs one shared restoring divider three times (out_R, out_C, tile
// count) and presents the result in DONE until out_ready_i. Invalid descriptors
// go straight from LOAD to DONE with err_o set.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    layer_tile_planner_if.slave (descriptor in, result out, flush)
//
// Optional feature: define ULD_TILE_CLAMP_EN to clamp channel tiles to the
// descriptor's channel counts; without it the fixed per-layer tables are used.
//
// The interface instance must use the same DIM_W / CH_W / DIV_W as this module.
`timescale 1ns/1ps

module layer_tile_planner #(
  parameter int unsigned GLB_BYTES = 65536,
  parameter int unsigned BYTES_I   = 1,
  parameter int unsigned BYTES_W   = 1,
  parameter int unsigned BYTES_P   = 4,
  parameter int unsigned DIM_W     = 7,
  parameter int unsigned CH_W      = 11,
  parameter int unsigned DIV_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  layer_tile_planner_if.slave bus
);

  localparam int unsigned CW = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] GlbBytes = DIV_W'(GLB_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDivR,
    StDivC,
    StDivN,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Registered descriptor
  logic [1:0]       type_q;
  logic [DIM_W-1:0] in_r_q, in_c_q;
  logic [CH_W-1:0]  in_d_q, out_k_q;
  logic [1:0]       stride_q, pad_t_q, pad_b_q, pad_l_q, pad_r_q;

  // Working terms registered in LOAD
  logic [DIM_W-1:0] padded_r_q, padded_c_q, kdim_q;
  logic [6:0]       tile_d_q, tile_k_q;
  logic [DIV_W-1:0] num_n_q, t_q;
  logic             err_pend_q;
  logic [DIM_W-1:0] out_r_w_q, out_c_w_q;

  // Divider state
  logic [DIV_W-1:0] rem_q, quo_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Published result
  logic             out_valid_q, err_q;
  logic [DIM_W-1:0] out_r_q, out_c_q, pub_pad_r_q, pub_pad_c_q;
  logic [6:0]       pub_tile_d_q, pub_tile_k_q;
  logic [DIV_W-1:0] tile_n_q;

  logic accept, div_active, last;
  assign accept     = bus.in_valid_i && (state_q == StIdle) && !bus.flush_i;
  assign div_active = (state_q == StDivR) || (state_q == StDivC) || (state_q == StDivN);
  assign last       = (cnt_q == CW'(DIV_W - 1));

  // ---------------------------------------------------------------------------
  // LOAD: derived terms from the registered descriptor
  // ---------------------------------------------------------------------------
  logic             is_3x3;
  logic [DIM_W-1:0] kdim_c, padded_r_c, padded_c_c;
  logic [6:0]       tbl_d, tbl_k, tbl_df, tbl_kf;
  logic [6:0]       tile_d_c, tile_k_c, tile_df_c, tile_kf_c;
  logic [DIV_W-1:0] k_area, m_c, w_c, a_c, t_c, wa_c;
  logic             err_c;

  assign is_3x3     = (type_q == 2'd1) || (type_q == 2'd2);
  assign kdim_c     = is_3x3 ? DIM_W'(3) : DIM_W'(1);
  // Padding overflow wraps silently.
  assign padded_r_c = in_r_q + DIM_W'(pad_t_q) + DIM_W'(pad_b_q);
  assign padded_c_c = in_c_q + DIM_W'(pad_l_q) + DIM_W'(pad_r_q);

  always_comb begin
    tbl_d  = 7'd32;
    tbl_k  = 7'd32;
    tbl_df = 7'd32;
    tbl_kf = 7'd32;
    case (type_q)
      2'd1: begin
        tbl_d  = 7'd10;
        tbl_k  = 7'd10;
        tbl_df = 7'd1;
        tbl_kf = 7'd10;
      end
      2'd2: begin
        tbl_d  = 7'd10;
        tbl_k  = 7'd10;
        tbl_df = 7'd10;
        tbl_kf = 7'd10;
      end
      default: ;
    endcase
  end

`ifdef ULD_TILE_CLAMP_EN
  assign tile_d_c  = (in_d_q < CH_W'(tbl_d)) ? in_d_q[6:0] : tbl_d;
  assign tile_k_c  = (out_k_q < CH_W'(tbl_k)) ? out_k_q[6:0] : tbl_k;
  assign tile_df_c = (tile_d_c < tbl_df) ? tile_d_c : tbl_df;
  assign tile_kf_c = (tile_k_c < tbl_kf) ? tile_k_c : tbl_kf;
`else
  assign tile_d_c  = tbl_d;
  assign tile_k_c  = tbl_k;
  assign tile_df_c = tbl_df;
  assign tile_kf_c = tbl_kf;
`endif

  // Channel counts only matter when clamping is built in.
  logic unused_ch;
  assign unused_ch = ^{in_d_q, out_k_q};

  assign k_area = is_3x3 ? DIV_W'(9) : DIV_W'(1);
  // Line-buffer rows: one padded row plus one for DW/STD, a single pixel otherwise.
  assign m_c    = is_3x3 ? (DIV_W'(padded_c_c) + DIV_W'(1)) : DIV_W'(1);
  assign w_c    = k_area * DIV_W'(tile_df_c) * DIV_W'(tile_kf_c) * DIV_W'(BYTES_W);
  assign a_c    = m_c * DIV_W'(2) * DIV_W'(tile_d_c) * DIV_W'(BYTES_I);
  assign t_c    = DIV_W'(tile_d_c) * DIV_W'(BYTES_I) + DIV_W'(tile_k_c) * DIV_W'(BYTES_P);
  assign wa_c   = w_c + a_c;
  assign err_c  = (stride_q == 2'd0) || (padded_r_c < kdim_c) || (padded_c_c < kdim_c) ||
                  (wa_c >= GlbBytes);

  // ---------------------------------------------------------------------------
  // Shared restoring divider, one quotient bit per cycle
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] dividend, divisor, q_in, r_in, rem_nx, quo_nx;
  logic [DIV_W:0]   rem_sh, diff;
  logic             fits;

  always_comb begin
    dividend = '0;
    divisor  = '0;
    case (state_q)
      StDivR: begin
        dividend = DIV_W'(padded_r_q) - DIV_W'(kdim_q);
        divisor  = DIV_W'(stride_q);
      end
      StDivC: begin
        dividend = DIV_W'(padded_c_q) - DIV_W'(kdim_q);
        divisor  = DIV_W'(stride_q);
      end
      StDivN: begin
        dividend = num_n_q;
        divisor  = t_q;
      end
      default: ;
    endcase
  end

  // The first iteration takes its operands directly, so no load cycle is needed.
  assign q_in   = (cnt_q == '0) ? dividend : quo_q;
  assign r_in   = (cnt_q == '0) ? '0 : rem_q;
  assign rem_sh = {r_in, q_in[DIV_W-1]};
  assign diff   = rem_sh - {1'b0, divisor};
  assign fits   = !diff[DIV_W];
  assign rem_nx = fits ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
  assign quo_nx = {q_in[DIV_W-2:0], fits};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (bus.flush_i) begin
      state_d = StIdle;
    end else begin
      if (div_active && !last) cnt_d = cnt_q + CW'(1);
      case (state_q)
        StIdle:  if (bus.in_valid_i) state_d = StLoad;
        StLoad:  state_d = err_c ? StDone : StDivR;
        StDivR:  if (last) state_d = StDivC;
        StDivC:  if (last) state_d = StDivN;
        StDivN:  if (last) state_d = StDone;
        StDone:  if (out_valid_q && bus.out_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q       <= '0;
      in_r_q       <= '0;
      in_c_q       <= '0;
      in_d_q       <= '0;
      out_k_q      <= '0;
      stride_q     <= '0;
      pad_t_q      <= '0;
      pad_b_q      <= '0;
      pad_l_q      <= '0;
      pad_r_q      <= '0;
      padded_r_q   <= '0;
      padded_c_q   <= '0;
      kdim_q       <= '0;
      tile_d_q     <= '0;
      tile_k_q     <= '0;
      num_n_q      <= '0;
      t_q          <= '0;
      err_pend_q   <= 1'b0;
      out_r_w_q    <= '0;
      out_c_w_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      out_r_q      <= '0;
      out_c_q      <= '0;
      pub_pad_r_q  <= '0;
      pub_pad_c_q  <= '0;
      pub_tile_d_q <= '0;
      pub_tile_k_q <= '0;
      tile_n_q     <= '0;
    end else begin
      if (accept) begin
        type_q   <= bus.layer_type_i;
        in_r_q   <= bus.in_R_i;
        in_c_q   <= bus.in_C_i;
        in_d_q   <= bus.in_D_i;
        out_k_q  <= bus.out_K_i;
        stride_q <= bus.stride_i;
        pad_t_q  <= bus.pad_T_i;
        pad_b_q  <= bus.pad_B_i;
        pad_l_q  <= bus.pad_L_i;
        pad_r_q  <= bus.pad_R_i;
      end

      if (state_q == StLoad) begin
        padded_r_q <= padded_r_c;
        padded_c_q <= padded_c_c;
        kdim_q     <= kdim_c;
        tile_d_q   <= tile_d_c;
        tile_k_q   <= tile_k_c;
        num_n_q    <= GlbBytes - wa_c;
        t_q        <= t_c;
        err_pend_q <= err_c;
      end

      if (div_active) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if ((state_q == StDivR) && last) out_r_w_q <= quo_nx[DIM_W-1:0] + DIM_W'(1);
      if ((state_q == StDivC) && last) out_c_w_q <= quo_nx[DIM_W-1:0] + DIM_W'(1);

      // Results are published only when complete; a flush leaves them untouched.
      if (bus.flush_i) begin
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end else if ((state_q == StDivN) && last) begin
        out_valid_q  <= 1'b1;
        err_q        <= 1'b0;
        out_r_q      <= out_r_w_q;
        out_c_q      <= out_c_w_q;
        tile_n_q     <= {quo_nx[DIV_W-1:2], 2'b00};
        pub_pad_r_q  <= padded_r_q;
        pub_pad_c_q  <= padded_c_q;
        pub_tile_d_q <= tile_d_q;
        pub_tile_k_q <= tile_k_q;
      end else if ((state_q == StDone) && err_pend_q && !out_valid_q) begin
        out_valid_q  <= 1'b1;
        err_q        <= 1'b1;
        out_r_q      <= '0;
        out_c_q      <= '0;
        tile_n_q     <= '0;
        pub_pad_r_q  <= padded_r_q;
        pub_pad_c_q  <= padded_c_q;
        pub_tile_d_q <= tile_d_q;
        pub_tile_k_q <= tile_k_q;
      end else if ((state_q == StDone) && out_valid_q && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = (state_q == StIdle);
  assign bus.out_valid_o = out_valid_q;
  assign bus.err_o       = err_q;
  assign bus.out_R_o     = out_r_q;
  assign bus.out_C_o     = out_c_q;
  assign bus.padded_R_o  = pub_pad_r_q;
  assign bus.padded_C_o  = pub_pad_c_q;
  assign bus.tile_D_o    = pub_tile_d_q;
  assign bus.tile_K_o    = pub_tile_k_q;
  assign bus.tile_n_o    = tile_n_q;

endmodule

// File: tb/tb_layer_tile_planner.sv
// tb_layer_tile_planner: self-checking bench for layer_tile_planner.
// Directed scenarios plus randomized descriptors against an arithmetic model.
`timescale 1ns/1ps

module tb_layer_tile_planner;
  localparam int unsigned DIM_W = 7;
  localparam int unsigned CH_W  = 11;
  localparam int unsigned DIV_W = 32;
`ifdef ULD_TILE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_tile_planner_if #(.DIM_W(DIM_W), .CH_W(CH_W), .DIV_W(DIV_W)) bus ();
  layer_tile_planner_if #(.DIM_W(DIM_W), .CH_W(CH_W), .DIV_W(DIV_W)) bus_s ();

  layer_tile_planner #(
    .GLB_BYTES(65536), .BYTES_I(1), .BYTES_W(1), .BYTES_P(4),
    .DIM_W(DIM_W), .CH_W(CH_W), .DIV_W(DIV_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  layer_tile_planner #(
    .GLB_BYTES(1000), .BYTES_I(1), .BYTES_W(1), .BYTES_P(4),
    .DIM_W(DIM_W), .CH_W(CH_W), .DIV_W(DIV_W)
  ) dut_small (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int out_r, out_c, pad_r, pad_c, td, tk, tn, lat;
    bit err;
  } exp_t;

  // Reference model computed directly from the planning rules.
  function automatic exp_t model(input int glb, input int typ, input int r, input int c,
                                 input int d, input int k, input int s, input int pt,
                                 input int pb, input int pl, input int pr);
    exp_t e;
    int kk, tdf, tkf, m, w, a, t, n;
    e.pad_r = (r + pt + pb) % 128;
    e.pad_c = (c + pl + pr) % 128;
    kk = (typ == 1 || typ == 2) ? 3 : 1;
    if (typ == 1) begin
      e.td = 10; e.tk = 10; tdf = 1;  tkf = 10;
    end else if (typ == 2) begin
      e.td = 10; e.tk = 10; tdf = 10; tkf = 10;
    end else begin
      e.td = 32; e.tk = 32; tdf = 32; tkf = 32;
    end
    if (CLAMP) begin
      if (d < e.td) e.td = d;
      if (k < e.tk) e.tk = k;
      if (e.td < tdf) tdf = e.td;
      if (e.tk < tkf) tkf = e.tk;
    end
    m = (kk == 3) ? e.pad_c + 1 : 1;
    w = kk * kk * tdf * tkf;
    a = m * 2 * e.td;
    t = e.td + 4 * e.tk;
    e.err = (s == 0) || (e.pad_r < kk) || (e.pad_c < kk) || (w + a >= glb);
    if (e.err) begin
      e.out_r = 0; e.out_c = 0; e.tn = 0; e.lat = 2;
    end else begin
      e.out_r = ((e.pad_r - kk) / s + 1) % 128;
      e.out_c = ((e.pad_c - kk) / s + 1) % 128;
      n = (glb - w - a) / t;
      e.tn = n - (n % 4);
      e.lat = 97;
    end
    return e;
  endfunction

  task automatic drive_desc(input int typ, input int r, input int c, input int d, input int k,
                            input int s, input int pt, input int pb, input int pl, input int pr);
    bus.layer_type_i = 2'(typ);
    bus.in_R_i = 7'(r);
    bus.in_C_i = 7'(c);
    bus.in_D_i = 11'(d);
    bus.out_K_i = 11'(k);
    bus.stride_i = 2'(s);
    bus.pad_T_i = 2'(pt);
    bus.pad_B_i = 2'(pb);
    bus.pad_L_i = 2'(pl);
    bus.pad_R_i = 2'(pr);
  endtask

  // Sends one descriptor; lat = edges from accept to out_valid, or -1 on timeout.
  task automatic run_desc(input int typ, input int r, input int c, input int d, input int k,
                          input int s, input int pt, input int pb, input int pl, input int pr,
                          output int lat);
    int guard;
    @(negedge clk);
    drive_desc(typ, r, c, d, k, s, pt, pb, pl, pr);
    bus.in_valid_i = 1'b1;
    guard = 0;
    while (bus.in_ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_desc();
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o);
    end
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_err: got %b%b want 00", bus.out_valid_o, bus.err_o);
    end
    n_checks++;
    if ({bus.out_R_o, bus.out_C_o, bus.padded_R_o, bus.padded_C_o, bus.tile_D_o, bus.tile_K_o,
         bus.tile_n_o} !== '0) begin
      n_fail++; $display("FAIL reset_results: got out_R=%0d tile_n=%0d want 0", bus.out_R_o,
                         bus.tile_n_o);
    end
  endtask

  task automatic test_pw();
    int lat;
    run_desc(0, 56, 56, 32, 64, 1, 0, 0, 0, 0, lat);
    n_checks++;
    if (lat !== 97) begin n_fail++; $display("FAIL pw_latency: got %0d want 97", lat); end
    n_checks++;
    if (bus.out_R_o !== 7'd56 || bus.out_C_o !== 7'd56) begin
      n_fail++; $display("FAIL pw_out_rc: got %0d x %0d want 56 x 56", bus.out_R_o, bus.out_C_o);
    end
    n_checks++;
    if (bus.tile_D_o !== 7'd32 || bus.tile_K_o !== 7'd32) begin
      n_fail++; $display("FAIL pw_tile: got %0d/%0d want 32/32", bus.tile_D_o, bus.tile_K_o);
    end
    n_checks++;
    if (bus.tile_n_o !== 32'd400) begin
      n_fail++; $display("FAIL pw_tile_n: got %0d want 400", bus.tile_n_o);
    end
    n_checks++;
    if (bus.err_o !== 1'b0 || bus.padded_R_o !== 7'd56) begin
      n_fail++; $display("FAIL pw_err_pad: got err=%b pad=%0d want 0/56", bus.err_o,
                         bus.padded_R_o);
    end
    finish_desc();
  endtask

  task automatic test_dw();
    int lat;
    run_desc(1, 112, 112, 32, 32, 2, 1, 1, 1, 1, lat);
    n_checks++;
    if (lat !== 97) begin n_fail++; $display("FAIL dw_latency: got %0d want 97", lat); end
    n_checks++;
    if (bus.padded_R_o !== 7'd114 || bus.padded_C_o !== 7'd114) begin
      n_fail++; $display("FAIL dw_padded: got %0d x %0d want 114", bus.padded_R_o,
                         bus.padded_C_o);
    end
    n_checks++;
    if (bus.out_R_o !== 7'd56 || bus.out_C_o !== 7'd56) begin
      n_fail++; $display("FAIL dw_out_rc: got %0d x %0d want 56 x 56", bus.out_R_o, bus.out_C_o);
    end
    n_checks++;
    if (bus.tile_D_o !== 7'd10 || bus.tile_K_o !== 7'd10 || bus.tile_n_o !== 32'd1260) begin
      n_fail++; $display("FAIL dw_tile: got %0d/%0d n=%0d want 10/10 n=1260", bus.tile_D_o,
                         bus.tile_K_o, bus.tile_n_o);
    end
    finish_desc();
  endtask

  task automatic test_err_stride();
    int lat;
    run_desc(0, 56, 56, 32, 64, 0, 0, 0, 0, 0, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL err_stride_latency: got %0d want 2", lat); end
    n_checks++;
    if (bus.err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_stride_flag: got %b want 1", bus.err_o);
    end
    n_checks++;
    if (bus.out_R_o !== 7'd0 || bus.out_C_o !== 7'd0 || bus.tile_n_o !== 32'd0) begin
      n_fail++; $display("FAIL err_stride_zero: got %0d %0d %0d want 0 0 0", bus.out_R_o,
                         bus.out_C_o, bus.tile_n_o);
    end
    finish_desc();
  endtask

  task automatic test_small_glb();
    int lat;
    @(negedge clk);
    bus_s.layer_type_i = 2'd0;
    bus_s.in_R_i = 7'd56;
    bus_s.in_C_i = 7'd56;
    bus_s.in_D_i = 11'd32;
    bus_s.out_K_i = 11'd64;
    bus_s.stride_i = 2'd1;
    bus_s.in_valid_i = 1'b1;
    @(posedge clk);
    #1 bus_s.in_valid_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus_s.out_valid_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL small_glb_latency: got %0d want 2", lat); end
    n_checks++;
    if (bus_s.err_o !== 1'b1 || bus_s.tile_n_o !== 32'd0) begin
      n_fail++; $display("FAIL small_glb_err: got err=%b n=%0d want 1/0", bus_s.err_o,
                         bus_s.tile_n_o);
    end
    bus_s.out_ready_i = 1'b1;
    @(posedge clk);
    #1 bus_s.out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    run_desc(0, 56, 56, 32, 64, 1, 0, 0, 0, 0, lat);
    n_checks++;
    if (lat !== 97) begin n_fail++; $display("FAIL bp_latency: got %0d want 97", lat); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.tile_n_o !== 32'd400 ||
          bus.out_R_o !== 7'd56 || bus.tile_D_o !== 7'd32) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b rdy=%b n=%0d want 1 0 400", i,
                           bus.out_valid_o, bus.in_ready_o, bus.tile_n_o);
      end
    end
    finish_desc();
    n_checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b v=%b want 1 0", bus.in_ready_o,
                         bus.out_valid_o);
    end
    run_desc(1, 112, 112, 32, 32, 2, 1, 1, 1, 1, lat);
    n_checks++;
    if (lat !== 97 || bus.tile_n_o !== 32'd1260) begin
      n_fail++; $display("FAIL bp_next: got lat=%0d n=%0d want 97 1260", lat, bus.tile_n_o);
    end
    finish_desc();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    // Previous published result is the DW descriptor (tile_n 1260).
    @(negedge clk);
    drive_desc(0, 56, 56, 32, 64, 1, 0, 0, 0, 0);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    repeat (45) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    n_checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got rdy=%b v=%b err=%b want 1 0 0", bus.in_ready_o,
                         bus.out_valid_o, bus.err_o);
    end
    n_checks++;
    if (bus.tile_n_o !== 32'd1260 || bus.out_R_o !== 7'd56) begin
      n_fail++; $display("FAIL flush_retain: got n=%0d want 1260", bus.tile_n_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: got 1 want 0"); end
    run_desc(0, 56, 56, 32, 64, 1, 0, 0, 0, 0, lat);
    n_checks++;
    if (lat !== 97 || bus.tile_n_o !== 32'd400) begin
      n_fail++; $display("FAIL flush_next: got lat=%0d n=%0d want 97 400", lat, bus.tile_n_o);
    end
    finish_desc();
  endtask

  task automatic test_flush_priority();
    @(negedge clk);
    drive_desc(0, 56, 56, 32, 64, 1, 0, 0, 0, 0);
    bus.in_valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_priority: got in_ready=%b want 1", bus.in_ready_o);
    end
  endtask

  task automatic test_clamp();
    int lat;
    int want_t, want_n;
    want_t = CLAMP ? 16 : 32;
    want_n = CLAMP ? 812 : 400;
    run_desc(0, 56, 56, 16, 16, 1, 0, 0, 0, 0, lat);
    n_checks++;
    if (int'(bus.tile_D_o) !== want_t || int'(bus.tile_K_o) !== want_t) begin
      n_fail++; $display("FAIL clamp_tile: got %0d/%0d want %0d", bus.tile_D_o, bus.tile_K_o,
                         want_t);
    end
    n_checks++;
    if (int'(bus.tile_n_o) !== want_n || lat !== 97) begin
      n_fail++; $display("FAIL clamp_tile_n: got %0d lat=%0d want %0d lat=97", bus.tile_n_o,
                         lat, want_n);
    end
    finish_desc();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive_desc(1, 112, 112, 32, 32, 2, 1, 1, 1, 1);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.tile_n_o !== 32'd0 || bus.out_R_o !== 7'd0 ||
        bus.tile_D_o !== 7'd0) begin
      n_fail++; $display("FAIL reset_midflight: got v=%b n=%0d want 0 0", bus.out_valid_o,
                         bus.tile_n_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_midflight_idle: got in_ready=%b want 1", bus.in_ready_o);
    end
  endtask

  task automatic test_random();
    int lat, typ, r, c, d, k, s, pt, pb, pl, pr;
    exp_t e;
    for (int it = 0; it < 40; it++) begin
      typ = $urandom_range(3, 0);
      r = $urandom_range(127, 0);
      c = $urandom_range(127, 0);
      d = $urandom_range(40, 1);
      k = $urandom_range(40, 1);
      s = $urandom_range(3, 0);
      pt = $urandom_range(3, 0);
      pb = $urandom_range(3, 0);
      pl = $urandom_range(3, 0);
      pr = $urandom_range(3, 0);
      e = model(65536, typ, r, c, d, k, s, pt, pb, pl, pr);
      run_desc(typ, r, c, d, k, s, pt, pb, pl, pr, lat);
      n_checks++;
      if (lat !== e.lat || bus.err_o !== e.err) begin
        n_fail++; $display("FAIL rnd%0d_lat_err: got lat=%0d err=%b want %0d %b", it, lat,
                           bus.err_o, e.lat, e.err);
      end
      n_checks++;
      if (int'(bus.out_R_o) !== e.out_r || int'(bus.out_C_o) !== e.out_c ||
          int'(bus.tile_n_o) !== e.tn) begin
        n_fail++; $display("FAIL rnd%0d_result: got %0d %0d n=%0d want %0d %0d n=%0d", it,
                           bus.out_R_o, bus.out_C_o, bus.tile_n_o, e.out_r, e.out_c, e.tn);
      end
      if (!e.err) begin
        n_checks++;
        if (int'(bus.padded_R_o) !== e.pad_r || int'(bus.padded_C_o) !== e.pad_c ||
            int'(bus.tile_D_o) !== e.td || int'(bus.tile_K_o) !== e.tk) begin
          n_fail++; $display("FAIL rnd%0d_derived: got pad %0d %0d tile %0d/%0d want %0d %0d %0d/%0d",
                             it, bus.padded_R_o, bus.padded_C_o, bus.tile_D_o, bus.tile_K_o,
                             e.pad_r, e.pad_c, e.td, e.tk);
        end
      end
      finish_desc();
    end
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    drive_desc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus_s.flush_i = 1'b0;
    bus_s.in_valid_i = 1'b0;
    bus_s.out_ready_i = 1'b0;
    bus_s.layer_type_i = 2'd0;
    bus_s.in_R_i = '0;
    bus_s.in_C_i = '0;
    bus_s.in_D_i = '0;
    bus_s.out_K_i = '0;
    bus_s.stride_i = 2'd0;
    bus_s.pad_T_i = 2'd0;
    bus_s.pad_B_i = 2'd0;
    bus_s.pad_L_i = 2'd0;
    bus_s.pad_R_i = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_pw();
    test_dw();
    test_err_stride();
    test_small_glb();
    test_backpressure();
    test_flush();
    test_flush_priority();
    test_clamp();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
